mac_acc64: RTL

MAC_ACC64 -- requirements
Module: mac_acc64

---
 rtl/mac_acc64.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mac_acc64.sv
// Streaming 32x32 multiply-accumulate front end with 64-bit group accumulator.
// The multiplier is external; a tag pipe tracks which returning products belong to a group.
module mac_acc64 #(
  parameter int unsigned MULT_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_multa_ns,
  input  logic        i_multb_ns,
  input  logic [31:0] i_multa,
  input  logic [31:0] i_multb,
  input  logic        i_last,
  output logic        o_multa_ns,
  output logic        o_multb_ns,
  output logic [31:0] o_multa,
  output logic [31:0] o_multb,
  input  logic [63:0] i_product,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [63:0] o_res,
  output logic        o_ovf
);

  typedef enum logic [1:0] {StAcc, StDrain, StHold} state_e;

  typedef struct packed {
    logic vld;
    logic last;
    logic sgn;
  } tag_t;

  state_e      state_q;
  logic        ready_q, res_valid_q;
  tag_t        tag_q [MULT_LAT];
  tag_t        tag_in, tag_out;
  logic [63:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic        first_q, first_d;
  logic        accept;
  logic [64:0] sum;
  logic        carry, sovf;

  assign o_multa_ns = i_multa_ns;
  assign o_multb_ns = i_multb_ns;
  assign o_multa    = i_multa;
  assign o_multb    = i_multb;

  assign accept  = i_valid & ready_q;
  assign tag_in  = '{vld: accept, last: i_last & accept, sgn: i_multa_ns | i_multb_ns};
  assign tag_out = tag_q[MULT_LAT-1];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < int'(MULT_LAT); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < int'(MULT_LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign sum   = {1'b0, acc_q} + {1'b0, i_product};
  assign carry = sum[64];
  // Signed overflow: operands share a sign that the result does not.
  assign sovf  = (acc_q[63] == i_product[63]) && (sum[63] != acc_q[63]);

  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    first_d = first_q;
    if (state_q == StHold && i_res_ready) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      first_d = 1'b1;
    end else if (tag_out.vld) begin
      if (first_q) begin
        acc_d   = i_product;
        first_d = 1'b0;
      end else begin
        acc_d = sum[63:0];
        ovf_d = ovf_q | (tag_out.sgn ? sovf : carry);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= StAcc;
      ready_q     <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (accept && i_last) begin
            state_q <= StDrain;
            ready_q <= 1'b0;
          end
        end
        StDrain: begin
          if (tag_out.vld && tag_out.last) begin
            state_q     <= StHold;
            res_valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (i_res_ready) begin
            state_q     <= StAcc;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StAcc;
          ready_q     <= 1'b1;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_res_valid = res_valid_q;
  assign o_res       = acc_q;
  assign o_ovf       = ovf_q;

endmodule
